// File: rtl/mult_pkg.sv
// mult_pkg: shared state type and sizing helpers for the digit-serial multiplier.
package mult_pkg;
   typedef enum logic [1:0] {IDLE, MULT, FIX} mult_state_t;
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic int calc_digits(input int width, input int dig);
      return width / dig;
   endfunction
   function automatic int calc_steps(input int width, input int a_dig, input int b_dig);
      return calc_digits(width, a_dig) * calc_digits(width, b_dig);
   endfunction
endpackage

// File: rtl/mult_digit.sv
// mult_digit: one A_DIGIT x B_DIGIT unsigned partial product, left-shifted into a 2*WIDTH lane.
module mult_digit #(
   parameter int WIDTH   = 32,
   parameter int A_DIGIT = 8,
   parameter int B_DIGIT = 16,
   parameter int SW      = 6
) (
   input  logic [A_DIGIT-1:0] a_dig,
   input  logic [B_DIGIT-1:0] b_dig,
   input  logic [SW-1:0]      shamt,
   output logic [2*WIDTH-1:0] pp
);
   logic [A_DIGIT+B_DIGIT-1:0] raw;
   always_comb begin
      raw = {{B_DIGIT{1'b0}}, a_dig} * {{A_DIGIT{1'b0}}, b_dig};
      pp  = (2*WIDTH)'(raw) << shamt;
   end
endmodule

// File: rtl/mult_nxn_seq.sv
// mult_nxn_seq: digit-serial WIDTHxWIDTH multiplier, one partial product accumulated per clock.
// Define MULT_SIGNED_EN to add the signed_op port and the two's-complement FIX step.
module mult_nxn_seq
   import mult_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int A_DIGIT = 8,
   parameter int B_DIGIT = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
`ifdef MULT_SIGNED_EN
   input  logic               signed_op,
`endif
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   localparam int NA = calc_digits(WIDTH, A_DIGIT);
   localparam int NB = calc_digits(WIDTH, B_DIGIT);
   localparam int IW = cnt_w(NA);
   localparam int JW = cnt_w(NB);
   localparam int SW = cnt_w(2*WIDTH);

   if (WIDTH % A_DIGIT != 0) begin : g_bad_a
      $error("mult_nxn_seq: WIDTH must be a multiple of A_DIGIT");
   end
   if (WIDTH % B_DIGIT != 0) begin : g_bad_b
      $error("mult_nxn_seq: WIDTH must be a multiple of B_DIGIT");
   end

   mult_state_t        state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, product_q, product_d;
   logic [IW-1:0]      i_q, i_d;
   logic [JW-1:0]      j_q, j_d;
   logic               sop_q, sop_d, neg_q, neg_d, done_q, done_d;
   logic               sop_in, neg_a, neg_b, i_last, j_last;
   logic [31:0]        a_off, b_off;
   logic [A_DIGIT-1:0] a_dig;
   logic [B_DIGIT-1:0] b_dig;
   logic [2*WIDTH-1:0] pp;

`ifdef MULT_SIGNED_EN
   assign sop_in = signed_op;
`else
   assign sop_in = 1'b0;
`endif

   // Signed mode stores magnitudes; -a of the most-negative value is its own unsigned magnitude.
   assign neg_a  = sop_in & a[WIDTH-1];
   assign neg_b  = sop_in & b[WIDTH-1];
   assign i_last = (i_q == IW'(NA-1));
   assign j_last = (j_q == JW'(NB-1));
   assign a_off  = 32'(i_q) * A_DIGIT;
   assign b_off  = 32'(j_q) * B_DIGIT;
   assign a_dig  = A_DIGIT'(a_q >> a_off);
   assign b_dig  = B_DIGIT'(b_q >> b_off);

   mult_digit #(
      .WIDTH   (WIDTH),
      .A_DIGIT (A_DIGIT),
      .B_DIGIT (B_DIGIT),
      .SW      (SW)
   ) u_digit (
      .a_dig (a_dig),
      .b_dig (b_dig),
      .shamt (SW'(a_off + b_off)),
      .pp    (pp)
   );

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      sop_d     = sop_q;
      neg_d     = neg_q;
      acc_d     = acc_q;
      i_d       = i_q;
      j_d       = j_q;
      product_d = product_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            a_d     = neg_a ? -a : a;
            b_d     = neg_b ? -b : b;
            sop_d   = sop_in;
            neg_d   = neg_a ^ neg_b;
            acc_d   = '0;
            i_d     = '0;
            j_d     = '0;
            state_d = MULT;
         end
         MULT: begin
            acc_d = acc_q + pp;
            i_d   = i_last ? '0 : i_q + 1'b1;
            j_d   = i_last ? (j_last ? '0 : j_q + 1'b1) : j_q;
            if (i_last && j_last) begin
               state_d   = sop_q ? FIX : IDLE;
               product_d = sop_q ? product_q : acc_d;
               done_d    = !sop_q;
            end
         end
         FIX: begin
            product_d = neg_q ? -acc_q : acc_q;
            done_d    = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         sop_q     <= 1'b0;
         neg_q     <= 1'b0;
         acc_q     <= '0;
         i_q       <= '0;
         j_q       <= '0;
         product_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         sop_q     <= sop_d;
         neg_q     <= neg_d;
         acc_q     <= acc_d;
         i_q       <= i_d;
         j_q       <= j_d;
         product_q <= product_d;
         done_q    <= done_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign product = product_q;
endmodule

// File: doc/mult_nxn_seq.md
Name: mult_nxn_seq

Overview:
- Parametrised multi-cycle integer multiplier; next generation of the fixed 32x32 sequential multiplier.
- Operands are split into A_DIGIT-bit and B_DIGIT-bit digits. One digit-pair partial product is shifted and accumulated per clock.
- Start/busy handshake plus a one-cycle done pulse.
- Sits as a datapath co-unit beside the ALU; compiles optionally with signed support.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH.
- A_DIGIT, 8, bits of a consumed per partial product; WIDTH % A_DIGIT must be 0.
- B_DIGIT, 16, bits of b consumed per partial product; WIDTH % B_DIGIT must be 0.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only in IDLE.
- a  in  WIDTH  multiplicand; sampled on the accepting edge.
- b  in  WIDTH  multiplier; sampled on the accepting edge.
- signed_op  in  1  two's-complement mode; present only with MULT_SIGNED_EN; sampled with a/b.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when product is updated.
- product  out  2*WIDTH  last completed result; holds between operations.

Behaviour:
- Definitions: NA=WIDTH/A_DIGIT, NB=WIDTH/B_DIGIT, N=NA*NB.
- Illegal parameter divisibility causes an elaboration $error.
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, product=0; accumulator, counters and operand registers =0.
- Reset mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, MULT, FIX (FIX exists only with MULT_SIGNED_EN).
- IDLE:
  - start=1 at edge k: latch a, b (and signed_op); clear accumulator; digit counters i=0, j=0; go to MULT; busy=1 from edge k.
- MULT (one edge per partial product):
  - acc += (a_digit[i] * b_digit[j]) << (i*A_DIGIT + j*B_DIGIT).
  - Iteration order: i fastest, then j.
  - Partial product width is A_DIGIT+B_DIGIT. The accumulator is 2*WIDTH wide; no overflow is possible.
  - On the N-th MULT edge (edge k+N), unsigned build or signed_op=0: product <= final acc; busy=0; done=1 for the following cycle; go to IDLE.
- Latency: unsigned = N cycles from the accepting edge to product valid. Default config: N=4*2=8.
- start while busy=1 is ignored, with no effect on operands or result.
- start=1 in the cycle done=1 is accepted (state is IDLE): back-to-back throughput of one op per N+1 cycles.
- a/b changes after acceptance have no effect.
- product changes only on a completion edge; no intermediate accumulator values are visible.
- done is never asserted while busy=1.

Optional Feature:
- MULT_SIGNED_EN defined:
  - signed_op port exists.
  - With signed_op=1, magnitudes of a and b are latched. The result sign is XOR of the operand MSBs.
  - After the last MULT edge, go to FIX; the FIX edge writes product <= sign ? -acc : acc, then done.
  - Signed latency = N+1.
  - Most-negative operand (0x80000000) handled correctly: its magnitude is 2^(WIDTH-1), held unsigned.
  - signed_op=0 behaves exactly like the unsigned build (latency N).
- MULT_SIGNED_EN not defined:
  - No signed_op port and no FIX state.
  - Unsigned only; latency always N.

Decomposition:
- Package mult_pkg holds:
  - state enum mult_state_t {IDLE, MULT, FIX};
  - function clog2-based counter width helper;
  - localparam-style functions for NA/NB/N computation.
- Sub-module mult_digit: combinational A_DIGIT x B_DIGIT unsigned multiplier with programmable left shift to 2*WIDTH bits. Instantiated once; the top holds the FSM, counters, operand/sign registers and accumulator.

Test Plan:
1. Reset: hold reset=0 for 4 cycles, then release -> busy=0, done=0, product=0; pulse reset=0 mid-op at cycle 3 -> busy=0 immediately, no done, product stays 0.
2. Defaults: a=0xFFFFFFFF, b=0xFFFFFFFF, one-cycle start -> product=0xFFFFFFFE00000001 exactly 8 edges after the accepting edge; busy high for 8 cycles; done high for exactly 1 cycle.
3. Busy rejection: a=0x12345678, b=0x9ABCDEF0, then start=1 at cycles 2 and 5 with a=b=0 -> product=0x0B00EA4E242D2080, single done.
4. Back-to-back: hold start=1 continuously with a=3/b=7, then a=0x10000/b=0x10000 -> products 21 then 0x100000000; done pulses 9 cycles apart.
5. Parameter sweep: WIDTH=16, A_DIGIT=4, B_DIGIT=4 -> 0xFFFF*0xFFFF=0xFFFE0001 after 16 cycles; 32 random vectors per config checked against a behavioural model.
6. MULT_SIGNED_EN: signed_op=1, a=-3, b=5 -> 0xFFFFFFFFFFFFFFF1 after 9 cycles; a=b=0x80000000 -> 0x4000000000000000; signed_op=0 with the same operands -> 0x4000000000000000 after 8 cycles.
